// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
// Declarations shared by the processor core and its instruction fetch stage.
//   - IW / PCW / DEPTH : instruction width, PC width, program memory depth
//   - HALT_WORD        : all-zero word that stops fetching
//   - instructions_t   : 4-bit opcode encoding (instruction bits [11:8])
//   - processor_state  : the core's six-state execution sequence
//   - fetch_state_t    : states of the fetch FSM
//   - is_halt()        : identifies the halt word
// ----------------------------------------------------------------------------
package proc_pkg;

    localparam int IW    = 12;
    localparam int PCW   = 8;
    localparam int DEPTH = 2 ** PCW;

    localparam logic [IW-1:0] HALT_WORD = 12'h000;

    typedef enum logic [3:0] {
        OP_HALT = 4'h0,
        OP_LOAD = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_JMP  = 4'h7,
        OP_JZ   = 4'h8,
        OP_NOP  = 4'hF
    } instructions_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        DECODE     = 3'd2,
        EXECUTE    = 3'd3,
        MEM_ACCESS = 3'd4,
        WRITE_BACK = 3'd5
    } processor_state;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        READ    = 2'd1,
        CHECK   = 2'd2,
        PRESENT = 2'd3
    } fetch_state_t;

    function automatic logic is_halt(input logic [IW-1:0] word);
        return (word == HALT_WORD);
    endfunction

endpackage

// File: rtl/inst_mem.sv
// ----------------------------------------------------------------------------
// inst_mem
// Program memory: DEPTH x W words, one write port and one synchronous read
// port with a single cycle of read latency. Contents have no reset.
//   clk     : clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   rd_en   : read strobe, mem[rd_addr] appears on rd_data after the edge
//   rd_data : registered read word, held while rd_en is low
// ----------------------------------------------------------------------------
module inst_mem
    import proc_pkg::*;
#(
    parameter int W      = IW,
    parameter int AW     = PCW,
    parameter int NWORDS = DEPTH
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_q [NWORDS];
    logic [W-1:0] rd_data_q;

    // Storage array write and registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage feeding the processor core. Holds the program
// memory and PC, offers one instruction at a time over valid/ready, follows
// jump redirects from the core and stops on the halt word.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   load_en/addr/data      : program load, only accepted while STOPPED
//   start                  : begin fetching at the current PC (STOPPED only)
//   inst_out, inst_valid   : offered instruction (zero while not valid)
//   inst_ready             : core consumes inst_out this cycle
//   redirect_en/pc         : jump target from the core (PRESENT only)
//   pc_out                 : current PC register
//   halted                 : fetch stopped on a halt word
//   busy                   : FSM not in STOPPED
//   fetch_count            : consumed-instruction counter (FETCH_COUNT_EN)
//
// Build option: define FETCH_COUNT_EN to add the 16-bit saturating
// fetch_count output.
// ----------------------------------------------------------------------------
module inst_fetch
    import proc_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load_en,
    input  logic [PCW-1:0] load_addr,
    input  logic [IW-1:0]  load_data,
    input  logic           start,
    output logic [IW-1:0]  inst_out,
    output logic           inst_valid,
    input  logic           inst_ready,
    input  logic           redirect_en,
    input  logic [PCW-1:0] redirect_pc,
    output logic [PCW-1:0] pc_out,
    output logic           halted,
    output logic           busy
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]    fetch_count
`endif
);

    localparam logic [PCW-1:0] PC_ONE = {{(PCW-1){1'b0}}, 1'b1};

    fetch_state_t   state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [IW-1:0]  inst_out_q, inst_out_d;
    logic           inst_valid_q, inst_valid_d;
    logic           halted_q, halted_d;

    logic           mem_we;
    logic           mem_re;
    logic [IW-1:0]  rd_word;

    // Loads are only accepted while idle so a running program is never
    // modified underneath the fetch; a load together with start still lands
    // before the first READ, because READ samples the memory one edge later.
    assign mem_we = load_en && (state_q == STOPPED);
    assign mem_re = (state_q == READ);

    inst_mem #(
        .W      (IW),
        .AW     (PCW),
        .NWORDS (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (mem_re),
        .rd_addr (pc_q),
        .rd_data (rd_word)
    );

    // Next-state, PC and handshake output logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_out_d   = inst_out_q;
        inst_valid_d = inst_valid_q;
        halted_d     = halted_q;

        case (state_q)
            STOPPED: begin
                if (start) begin
                    state_d  = READ;
                    halted_d = 1'b0;
                end else begin
                    state_d  = STOPPED;
                end
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (is_halt(rd_word)) begin
                    // PC stays on the halt address so the core can inspect it.
                    state_d  = STOPPED;
                    halted_d = 1'b1;
                end else begin
                    inst_out_d   = rd_word;
                    inst_valid_d = 1'b1;
                    state_d      = PRESENT;
                end
            end
            PRESENT: begin
                // A redirect wins over a plain advance whatever inst_ready is.
                if (redirect_en) begin
                    pc_d         = redirect_pc;
                    inst_out_d   = {IW{1'b0}};
                    inst_valid_d = 1'b0;
                    state_d      = READ;
                end else if (inst_ready) begin
                    pc_d         = pc_q + PC_ONE;
                    inst_out_d   = {IW{1'b0}};
                    inst_valid_d = 1'b0;
                    state_d      = READ;
                end else begin
                    state_d      = PRESENT;
                end
            end
            default: begin
                state_d      = STOPPED;
                inst_out_d   = {IW{1'b0}};
                inst_valid_d = 1'b0;
            end
        endcase
    end

    // FSM, PC and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= STOPPED;
            pc_q         <= {PCW{1'b0}};
            inst_out_q   <= {IW{1'b0}};
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_out_q   <= inst_out_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign inst_out   = inst_out_q;
    assign inst_valid = inst_valid_q;
    assign pc_out     = pc_q;
    assign halted     = halted_q;
    assign busy       = (state_q != STOPPED);

`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    // Consumed-instruction count: a redirect with inst_ready high still
    // consumes the word, so only inst_ready matters here.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if ((state_q == STOPPED) && start) begin
            fetch_count_d = 16'h0000;
        end else if ((state_q == PRESENT) && inst_ready && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'h0001;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= 16'h0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule
